// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master bus arbiter with serial slave addressing and split/resume.
// Macro ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins.
// Ports: sys_clk, sys_rst (async, active-high); m_request, m_slave_sel, trans_done,
//   s_split_en in; m_grant, bus_grant, slave_sel, arbiter_busy, bus_busy, split_pending out.
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 4,
  parameter int SLAVE_AW    = 2,
  localparam int NUM_SLAVES = 2**SLAVE_AW,
  localparam int MAW        = $clog2(NUM_MASTERS)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic [NUM_MASTERS-1:0] m_slave_sel,
  input  logic                   trans_done,
  input  logic [NUM_SLAVES-1:0]  s_split_en,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [MAW-1:0]         bus_grant,
  output logic [SLAVE_AW-1:0]    slave_sel,
  output logic                   arbiter_busy,
  output logic                   bus_busy,
  output logic                   split_pending
);

  localparam int CW = (SLAVE_AW > 1) ? $clog2(SLAVE_AW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_XFER
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [NUM_MASTERS-1:0] r_grant,     w_grant_d;
  logic [MAW-1:0]         r_bus_grant, w_bus_grant_d;
  logic [SLAVE_AW-1:0]    r_slave_sel, w_slave_sel_d;
  logic                   r_pending,   w_pending_d;
  logic [MAW-1:0]         r_park_m,    w_park_m_d;
  logic [SLAVE_AW-1:0]    r_park_s,    w_park_s_d;
  logic [SLAVE_AW-1:0]    r_addr_sr,   w_addr_sr_d;
  logic [CW-1:0]          r_bit_cnt,   w_bit_cnt_d;
  logic                   r_arb_busy;
  logic                   r_bus_busy;
`ifdef ROUND_ROBIN_EN
  logic [MAW-1:0]         r_rr_ptr,    w_rr_ptr_d;
`endif

  logic [NUM_MASTERS-1:0] w_park_mask;
  logic [NUM_MASTERS-1:0] w_elig;
  logic [MAW-1:0]         w_win;
  logic                   w_found;
  logic                   w_resume;
  logic                   w_last_bit;
  logic                   w_split_hit;
  logic [SLAVE_AW-1:0]    w_shift;

  // A parked master is invisible to arbitration until it resumes.
  always_comb begin
    w_park_mask = '0;
    if (r_pending) w_park_mask[r_park_m] = 1'b1;
  end

  assign w_elig      = m_request & ~w_park_mask;
  assign w_resume    = r_pending && !s_split_en[r_park_s];
  assign w_last_bit  = (r_bit_cnt == CW'(SLAVE_AW - 1));
  assign w_split_hit = s_split_en[r_slave_sel] && !trans_done
                       && !r_pending;
  assign w_shift     = (r_addr_sr << 1)
                       | SLAVE_AW'(m_slave_sel[r_bus_grant]);

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
`ifdef ROUND_ROBIN_EN
      if (!w_found &&
          w_elig[(int'(r_rr_ptr) + i) % NUM_MASTERS]) begin
        w_found = 1'b1;
        w_win   = MAW'((int'(r_rr_ptr) + i) % NUM_MASTERS);
      end
`else
      if (!w_found && w_elig[i]) begin
        w_found = 1'b1;
        w_win   = MAW'(i);
      end
`endif
    end
  end

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; resume outranks new requests
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_resume)     w_next = S_XFER;
        else if (w_found) w_next = S_ADDR;
      end
      S_ADDR: if (w_last_bit) w_next = S_XFER;
      S_XFER: if (trans_done || w_split_hit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_grant_d     = r_grant;
    w_bus_grant_d = r_bus_grant;
    w_slave_sel_d = r_slave_sel;
    w_pending_d   = r_pending;
    w_park_m_d    = r_park_m;
    w_park_s_d    = r_park_s;
    w_addr_sr_d   = r_addr_sr;
    w_bit_cnt_d   = r_bit_cnt;
`ifdef ROUND_ROBIN_EN
    w_rr_ptr_d    = r_rr_ptr;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_resume) begin
          w_grant_d             = '0;
          w_grant_d[r_park_m]   = 1'b1;
          w_bus_grant_d         = r_park_m;
          w_slave_sel_d         = r_park_s;
          w_pending_d           = 1'b0;
        end else if (w_found) begin
          w_grant_d             = '0;
          w_grant_d[w_win]      = 1'b1;
          w_bus_grant_d         = w_win;
          w_addr_sr_d           = '0;
          w_bit_cnt_d           = '0;
`ifdef ROUND_ROBIN_EN
          w_rr_ptr_d = (int'(w_win) == NUM_MASTERS - 1)
                       ? '0 : w_win + MAW'(1);
`endif
        end
      end
      S_ADDR: begin
        w_addr_sr_d = w_shift;
        w_bit_cnt_d = r_bit_cnt + CW'(1);
        if (w_last_bit) w_slave_sel_d = w_shift;
      end
      S_XFER: begin
        if (trans_done) begin
          w_grant_d = '0;
        end else if (w_split_hit) begin
          w_grant_d   = '0;
          w_pending_d = 1'b1;
          w_park_m_d  = r_bus_grant;
          w_park_s_d  = r_slave_sel;
        end
      end
      default: w_grant_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_grant     <= '0;
      r_bus_grant <= '0;
      r_slave_sel <= '0;
      r_pending   <= 1'b0;
      r_park_m    <= '0;
      r_park_s    <= '0;
      r_addr_sr   <= '0;
      r_bit_cnt   <= '0;
      r_arb_busy  <= 1'b0;
      r_bus_busy  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_rr_ptr    <= '0;
`endif
    end else begin
      r_grant     <= w_grant_d;
      r_bus_grant <= w_bus_grant_d;
      r_slave_sel <= w_slave_sel_d;
      r_pending   <= w_pending_d;
      r_park_m    <= w_park_m_d;
      r_park_s    <= w_park_s_d;
      r_addr_sr   <= w_addr_sr_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_arb_busy  <= (w_next != S_IDLE);
      r_bus_busy  <= (w_next == S_XFER);
`ifdef ROUND_ROBIN_EN
      r_rr_ptr    <= w_rr_ptr_d;
`endif
    end
  end

  assign m_grant       = r_grant;
  assign bus_grant     = r_bus_grant;
  assign slave_sel     = r_slave_sel;
  assign arbiter_busy  = r_arb_busy;
  assign bus_busy      = r_bus_busy;
  assign split_pending = r_pending;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: directed and random checks of bus_arbiter_n
// against a transaction-level reference model.
module tb_bus_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int NS = 4;

  logic          sys_clk;
  logic          sys_rst;
  logic [N-1:0]  m_request;
  logic [N-1:0]  m_slave_sel;
  logic          trans_done;
  logic [NS-1:0] s_split_en;
  logic [N-1:0]  m_grant;
  logic [1:0]    bus_grant;
  logic [AW-1:0] slave_sel;
  logic          arbiter_busy;
  logic          bus_busy;
  logic          split_pending;

  bus_arbiter_n #(.NUM_MASTERS(N), .SLAVE_AW(AW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .m_request    (m_request),
    .m_slave_sel  (m_slave_sel),
    .trans_done   (trans_done),
    .s_split_en   (s_split_en),
    .m_grant      (m_grant),
    .bus_grant    (bus_grant),
    .slave_sel    (slave_sel),
    .arbiter_busy (arbiter_busy),
    .bus_busy     (bus_busy),
    .split_pending(split_pending)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who owns the bus, how many address bits remain,
  // whether data is moving, and who is parked where.
  int cur, addr_left, addr_val, sel, last, park_m, park_s, rr_next;
  bit in_xfer;

  task automatic model_reset();
    cur = -1; addr_left = 0; addr_val = 0; sel = 0; last = 0;
    park_m = -1; park_s = 0; rr_next = 0; in_xfer = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req,
                            input logic [N-1:0] ssel,
                            input logic done,
                            input logic [NS-1:0] split);
    int w, idx;
    w = -1;
    if (in_xfer) begin
      if (done) begin
        in_xfer = 0; cur = -1;
      end else if (split[sel] && park_m < 0) begin
        park_m = cur; park_s = sel; in_xfer = 0; cur = -1;
      end
    end else if (addr_left > 0) begin
      addr_val = addr_val * 2 + int'(ssel[cur]);
      addr_left--;
      if (addr_left == 0) begin
        sel = addr_val; in_xfer = 1;
      end
    end else if (park_m >= 0 && !split[park_s]) begin
      cur = park_m; last = park_m; sel = park_s;
      park_m = -1; in_xfer = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
`ifdef ROUND_ROBIN_EN
        idx = (rr_next + k) % N;
`else
        idx = k;
`endif
        if (w < 0 && req[idx] && idx != park_m) w = idx;
      end
      if (w >= 0) begin
        cur = w; last = w; addr_left = AW; addr_val = 0;
        rr_next = (w + 1) % N;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"}, 32'(m_grant),
        cur >= 0 ? 32'(1) << cur : 32'd0);
    chk({tag, ".bus_grant"}, 32'(bus_grant), 32'(last));
    chk({tag, ".slave_sel"}, 32'(slave_sel), 32'(sel));
    chk({tag, ".arb_busy"}, 32'(arbiter_busy), 32'(cur >= 0));
    chk({tag, ".bus_busy"}, 32'(bus_busy), 32'(in_xfer));
    chk({tag, ".split"}, 32'(split_pending), 32'(park_m >= 0));
  endtask

  // Called at a falling edge; applies inputs for one rising edge.
  task automatic cyc(input string tag, input logic [N-1:0] req,
                     input logic [N-1:0] ssel, input logic done,
                     input logic [NS-1:0] split);
    m_request = req; m_slave_sel = ssel;
    trans_done = done; s_split_en = split;
    model_step(req, ssel, done, split);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_all(tag);
  endtask

  // Async reset away from any rising edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2 sys_rst = 1'b1;
    #1 model_reset();
    check_all(tag);
    chk({tag, ".zero"},
        32'({m_grant, bus_grant, slave_sel, arbiter_busy,
             bus_busy, split_pending}), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    m_request = '0; m_slave_sel = '0;
    trans_done = 1'b0; s_split_en = '0;
  endtask

  int exp_order[4];

  initial begin
`ifdef ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    sys_rst = 1'b1;
    m_request = '0; m_slave_sel = '0;
    trans_done = 1'b0; s_split_en = '0;
    model_reset();
    @(negedge sys_clk);
    check_all("reset");
    sys_rst = 1'b0;

    // Basic grant, serial address 1,0, completion
    cyc("b.grant", 4'b0100, 4'b0000, 0, 4'b0000);
    chk("b.grant1", 32'(m_grant), 32'b0100);
    cyc("b.a1", 4'b0000, 4'b0100, 0, 4'b0000);
    chk("b.nobusy", 32'(bus_busy), 0);
    cyc("b.a0", 4'b0000, 4'b0000, 0, 4'b0000);
    chk("b.sel", 32'(slave_sel), 32'b10);
    chk("b.busy", 32'(bus_busy), 1);
    cyc("b.done", 4'b0000, 4'b0000, 1, 4'b0000);
    chk("b.idx", 32'(bus_grant), 2);
    chk("b.idle", 32'(arbiter_busy), 0);

    // Four arbitrations with all masters requesting
    do_reset("r1");
    for (int k = 0; k < 4; k++) begin
      cyc("o.g", 4'b1111, 4'b0000, 0, 4'b0000);
      chk("o.order", 32'(bus_grant), 32'(exp_order[k]));
      cyc("o.a1", 4'b1111, 4'b0000, 0, 4'b0000);
      cyc("o.a0", 4'b1111, 4'b0000, 0, 4'b0000);
      cyc("o.d", 4'b1111, 4'b0000, 1, 4'b0000);
    end

    // Split and resume
    do_reset("r2");
    cyc("s.g0", 4'b0001, 4'b0000, 0, 4'b0000);
    cyc("s.a1", 4'b0000, 4'b0000, 0, 4'b0000);
    cyc("s.a0", 4'b0000, 4'b0001, 0, 4'b0000);
    chk("s.sel1", 32'(slave_sel), 1);
    cyc("s.park", 4'b0000, 4'b0000, 0, 4'b0010);
    chk("s.pend", 32'(split_pending), 1);
    chk("s.free", 32'(m_grant), 0);
    cyc("s.g3", 4'b1001, 4'b0000, 0, 4'b0010);
    chk("s.g3v", 32'(m_grant), 32'b1000);
    cyc("s.b1", 4'b1001, 4'b1000, 0, 4'b0010);
    cyc("s.b0", 4'b1001, 4'b0000, 0, 4'b0010);
    chk("s.sel2", 32'(slave_sel), 2);
    cyc("s.d3", 4'b1001, 4'b0000, 1, 4'b0010);
    cyc("s.res", 4'b0000, 4'b0000, 0, 4'b0000);
    chk("s.resg", 32'(m_grant), 32'b0001);
    chk("s.ress", 32'(slave_sel), 1);
    chk("s.resb", 32'(bus_busy), 1);
    chk("s.resp", 32'(split_pending), 0);
    cyc("s.d0", 4'b0000, 4'b0000, 1, 4'b0000);

    // Second split ignored; done beats split
    do_reset("r3");
    cyc("t.g1", 4'b0010, 4'b0000, 0, 4'b0000);
    cyc("t.a1", 4'b0000, 4'b0000, 0, 4'b0000);
    cyc("t.a0", 4'b0000, 4'b0000, 0, 4'b0000);
    cyc("t.park", 4'b0000, 4'b0000, 0, 4'b0001);
    cyc("t.g2", 4'b0100, 4'b0000, 0, 4'b0001);
    cyc("t.b1", 4'b0000, 4'b0100, 0, 4'b0001);
    cyc("t.b0", 4'b0000, 4'b0100, 0, 4'b0001);
    chk("t.sel3", 32'(slave_sel), 3);
    cyc("t.ign", 4'b0000, 4'b0000, 0, 4'b1001);
    chk("t.ignb", 32'(bus_busy), 1);
    chk("t.igng", 32'(m_grant), 32'b0100);
    cyc("t.ign2", 4'b0000, 4'b0000, 0, 4'b1001);
    cyc("t.d2", 4'b0000, 4'b0000, 1, 4'b1001);
    chk("t.d2p", 32'(split_pending), 1);
    cyc("t.res", 4'b0000, 4'b0000, 0, 4'b0000);
    cyc("t.d1", 4'b0000, 4'b0000, 1, 4'b0000);
    cyc("t.g0", 4'b0001, 4'b0000, 0, 4'b0000);
    cyc("t.c1", 4'b0000, 4'b0000, 0, 4'b0000);
    cyc("t.c0", 4'b0000, 4'b0001, 0, 4'b0000);
    cyc("t.both", 4'b0000, 4'b0000, 1, 4'b0010);
    chk("t.bothp", 32'(split_pending), 0);
    chk("t.bothb", 32'(bus_busy), 0);

    // Reset mid-ADDR and with a split pending
    cyc("x.g", 4'b0100, 4'b0000, 0, 4'b0000);
    cyc("x.a1", 4'b0000, 4'b0100, 0, 4'b0000);
    do_reset("x.rst_addr");
    cyc("x.g0", 4'b0001, 4'b0000, 0, 4'b0000);
    cyc("x.a1b", 4'b0000, 4'b0000, 0, 4'b0000);
    cyc("x.a0b", 4'b0000, 4'b0001, 0, 4'b0000);
    cyc("x.park", 4'b0000, 4'b0000, 0, 4'b0010);
    chk("x.pend", 32'(split_pending), 1);
    do_reset("x.rst_split");
    cyc("x.noresume", 4'b0000, 4'b0000, 0, 4'b0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [NS-1:0] sp;
      sp = '0;
      for (int b = 0; b < NS; b++)
        sp[b] = ($urandom_range(7) == 0);
      cyc("rnd", N'($urandom), N'($urandom),
          ($urandom_range(3) == 0), sp);
      if (i == 200) do_reset("rnd.rst");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
